// File: rtl/conv_ibuf_ctrl.sv
// Frame sequencer for the convolution input line buffer: accepts a raster pixel stream,
// drives buffer writes, tracks position and presents complete-window flags to the CIM stage.
module conv_ibuf_ctrl #(
  parameter int unsigned datatype_size = 8,
  parameter int unsigned img_width     = 28,
  parameter int unsigned img_height    = 28,
  parameter int unsigned kernel_dim    = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic                            i_valid,
  input  logic [datatype_size-1:0]        i_data,
  output logic                            o_ready,
  output logic                            o_write_enable,
  output logic [datatype_size-1:0]        o_ibuf_data,
  output logic                            o_win_valid,
  input  logic                            i_win_ready,
  output logic [$clog2(img_height)-1:0]   o_win_row,
  output logic [$clog2(img_width)-1:0]    o_win_col,
  output logic                            o_busy,
  output logic                            o_frame_done
);

  localparam int unsigned ROW_W     = $clog2(img_height);
  localparam int unsigned COL_W     = $clog2(img_width);
  localparam logic        SKIP_FILL = (kernel_dim == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              fill_end;
  logic              win_pos;
  logic              consume;

  // Stream is blocked only while a window is pending and not being taken this cycle.
  assign o_ready        = ((state_q == S_FILL) || (state_q == S_STREAM)) &&
                          !(o_win_valid && !i_win_ready);
  assign accept         = i_valid && o_ready;
  assign o_write_enable = accept;
  assign o_ibuf_data    = i_data;

  assign last_col = (col_q == COL_W'(img_width - 1));
  assign last_row = (row_q == ROW_W'(img_height - 1));
  assign fill_end = (row_q == ROW_W'(kernel_dim - 1)) && last_col;
  assign win_pos  = (row_q >= ROW_W'(kernel_dim - 1)) && (col_q >= COL_W'(kernel_dim - 1));
  assign consume  = o_win_valid && i_win_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      o_busy       <= (state_d != S_IDLE);
      o_frame_done <= (state_d == S_DONE);
    end
  end

  // Next state and raster position.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          row_d   = '0;
          col_d   = '0;
          state_d = SKIP_FILL ? S_STREAM : S_FILL;
        end
      end
      S_FILL: begin
        if (accept && last_col && last_row) begin
          state_d = S_DRAIN;
        end else if (accept && fill_end) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept && last_col && last_row) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!o_win_valid || i_win_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Window flag: a new window replaces one consumed on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_win_valid <= 1'b0;
      o_win_row   <= '0;
      o_win_col   <= '0;
    end else if (accept && win_pos) begin
      o_win_valid <= 1'b1;
      o_win_row   <= row_q - ROW_W'(kernel_dim - 1);
      o_win_col   <= col_q - COL_W'(kernel_dim - 1);
    end else if (consume) begin
      o_win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_ibuf_ctrl.sv
// Randomized bench for conv_ibuf_ctrl: windows, pixel stream and handshakes are checked
// against an order/position model derived from frame geometry.
module tb_conv_ibuf_ctrl;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int K    = 3;
  localparam int NWIN = (W - K + 1) * (H - K + 1);
  localparam int SW   = 5;
  localparam int SH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, valid = 1'b0, win_ready = 1'b0;
  logic [7:0] data = '0;
  logic       ready, we, win_valid, busy, done;
  logic [7:0] ibuf;
  logic [4:0] win_row, win_col;

  logic       b_start = 1'b0, b_valid = 1'b0, b_win_ready = 1'b0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_we, b_win_valid, b_busy, b_done;
  logic [7:0] b_ibuf;
  logic [1:0] b_win_row;
  logic [2:0] b_win_col;

  int checks = 0;
  int failures = 0;
  logic [7:0] pix [H*W];

  conv_ibuf_ctrl #(.datatype_size(8), .img_width(W), .img_height(H), .kernel_dim(K)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_write_enable(we), .o_ibuf_data(ibuf), .o_win_valid(win_valid),
    .i_win_ready(win_ready), .o_win_row(win_row), .o_win_col(win_col),
    .o_busy(busy), .o_frame_done(done)
  );

  conv_ibuf_ctrl #(.datatype_size(8), .img_width(SW), .img_height(SH), .kernel_dim(K)) dut_small (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_valid(b_valid), .i_data(b_data),
    .o_ready(b_ready), .o_write_enable(b_we), .o_ibuf_data(b_ibuf), .o_win_valid(b_win_valid),
    .i_win_ready(b_win_ready), .o_win_row(b_win_row), .o_win_col(b_win_col),
    .o_busy(b_busy), .o_frame_done(b_done)
  );

  // Drives one frame on the main DUT; must be entered at a negedge in IDLE.
  task automatic run_frame(input int valid_pct, input int ready_pct, input int stall_at,
                           input bit glitch, input bit linger,
                           output int n_win, output int n_pix, output int first_wr,
                           output int ord_err, output int data_err, output int hs_err,
                           output int stall_err, output int stall_cyc, output int n_done,
                           output bit timeout);
    int cyc, stall_cnt, er, ec;
    bit pending, seen_done, stalled, exp_ready;
    logic [4:0] held_r, held_c;
    n_win = 0; n_pix = 0; first_wr = -1; ord_err = 0; data_err = 0; hs_err = 0;
    stall_err = 0; stall_cyc = 0; n_done = 0; timeout = 0;
    cyc = 0; stall_cnt = 0; pending = 0; seen_done = 0; stalled = 0;
    held_r = '0; held_c = '0;
    foreach (pix[i]) pix[i] = 8'($urandom);
    start = 1'b1; valid = 1'b0; win_ready = 1'b0;
    @(negedge clk);
    while (!seen_done && !timeout) begin
      start     = glitch && (n_pix >= 5*W) && (n_pix < 6*W);
      valid     = (n_pix < H*W) && ($urandom_range(99) < valid_pct);
      data      = valid ? pix[n_pix] : 8'($urandom);
      win_ready = ($urandom_range(99) < ready_pct);
      if (stall_cnt > 0) begin
        win_ready = 1'b0;
        valid     = (n_pix < H*W);
        if (valid) data = pix[n_pix];
      end
      #1;
      if (win_valid && !pending && n_win == stall_at && !stalled) begin
        stalled = 1; stall_cnt = 5; held_r = win_row; held_c = win_col;
        win_ready = 1'b0;
        valid = (n_pix < H*W);
        if (valid) data = pix[n_pix];
        #1;
      end
      if (we !== (valid && ready)) hs_err++;
      exp_ready = (n_pix < H*W) && !(win_valid && !win_ready);
      if (ready !== exp_ready) hs_err++;
      if (win_valid && !pending) begin
        er = n_win / (W - K + 1);
        ec = n_win % (W - K + 1);
        if (win_row !== 5'(er) || win_col !== 5'(ec) || n_pix != (er + K - 1) * W + ec + K)
          ord_err++;
        if (first_wr < 0) first_wr = n_pix;
      end
      if (stall_cnt > 0) begin
        stall_cyc++;
        if (ready !== 1'b0 || we !== 1'b0 || win_valid !== 1'b1 ||
            win_row !== held_r || win_col !== held_c) stall_err++;
        stall_cnt--;
      end
      if (win_valid && win_ready) begin
        n_win++;
        pending = 0;
      end else begin
        pending = win_valid;
      end
      if (we) begin
        if (ibuf !== pix[n_pix]) data_err++;
        n_pix++;
      end
      if (done) begin
        n_done++;
        seen_done = 1;
      end
      cyc++;
      if (cyc > 20000) timeout = 1;
      @(negedge clk);
    end
    start = 1'b0; valid = 1'b0; win_ready = 1'b0;
    if (linger) begin
      repeat (3) begin
        #1;
        if (done) n_done++;
        if (busy) hs_err++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
    checks++; if (win_row !== 5'd0 || win_col !== 5'd0) begin failures++; $display("FAIL reset_win_pos got=(%0d,%0d) exp=(0,0)", win_row, win_col); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    int n_win, n_pix, first_wr, oe, de, he, se, sc, nd; bit to;
    run_frame(100, 100, -1, 0, 1, n_win, n_pix, first_wr, oe, de, he, se, sc, nd, to);
    checks++; if (to) begin failures++; $display("FAIL full_timeout got=1 exp=0"); end
    checks++; if (n_win != NWIN) begin failures++; $display("FAIL full_windows got=%0d exp=%0d", n_win, NWIN); end
    checks++; if (n_pix != H*W) begin failures++; $display("FAIL full_pixels got=%0d exp=%0d", n_pix, H*W); end
    checks++; if (first_wr != 59) begin failures++; $display("FAIL full_first_latency got=%0d exp=59", first_wr); end
    checks++; if (oe != 0) begin failures++; $display("FAIL full_window_order got=%0d errs exp=0", oe); end
    checks++; if (de != 0) begin failures++; $display("FAIL full_data got=%0d errs exp=0", de); end
    checks++; if (he != 0) begin failures++; $display("FAIL full_handshake got=%0d errs exp=0", he); end
    checks++; if (nd != 1) begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", nd); end
  endtask

  task automatic test_small_frame();
    int n_pix, n_win, n_done, cyc, er, ec;
    bit pending, seen;
    n_pix = 0; n_win = 0; n_done = 0; cyc = 0; pending = 0; seen = 0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (!seen && cyc < 2000) begin
      b_valid = (n_pix < SW*SH); b_data = 8'(n_pix); b_win_ready = 1'b1;
      #1;
      if (b_win_valid && !pending) begin
        er = n_win / (SW - K + 1);
        ec = n_win % (SW - K + 1);
        checks++;
        if (b_win_row !== 2'(er) || b_win_col !== 3'(ec) || n_pix != (er + K - 1) * SW + ec + K) begin
          failures++;
          $display("FAIL small_window[%0d] got=(%0d,%0d)@px%0d exp=(%0d,%0d)@px%0d",
                   n_win, b_win_row, b_win_col, n_pix, er, ec, (er + K - 1) * SW + ec + K);
        end
      end
      if (b_win_valid && b_win_ready) begin n_win++; pending = 0; end
      else pending = b_win_valid;
      if (b_we) n_pix++;
      if (b_done) begin n_done++; seen = 1; end
      cyc++;
      @(negedge clk);
    end
    b_valid = 1'b0; b_win_ready = 1'b0;
    checks++; if (n_win != 6) begin failures++; $display("FAIL small_windows got=%0d exp=6", n_win); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL small_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_stall();
    int n_win, n_pix, first_wr, oe, de, he, se, sc, nd; bit to;
    run_frame(100, 100, 100, 0, 1, n_win, n_pix, first_wr, oe, de, he, se, sc, nd, to);
    checks++; if (sc != 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", sc); end
    checks++; if (se != 0) begin failures++; $display("FAIL stall_hold got=%0d errs exp=0", se); end
    checks++; if (n_win != NWIN || oe != 0 || to) begin failures++; $display("FAIL stall_frame got=%0d wins %0d order errs exp=%0d wins 0 errs", n_win, oe, NWIN); end
  endtask

  task automatic test_random_gaps();
    int n_win, n_pix, first_wr, oe, de, he, se, sc, nd; bit to;
    run_frame(50, 60, -1, 0, 1, n_win, n_pix, first_wr, oe, de, he, se, sc, nd, to);
    checks++; if (to) begin failures++; $display("FAIL random_timeout got=1 exp=0"); end
    checks++; if (n_win != NWIN) begin failures++; $display("FAIL random_windows got=%0d exp=%0d", n_win, NWIN); end
    checks++; if (oe != 0) begin failures++; $display("FAIL random_window_order got=%0d errs exp=0", oe); end
    checks++; if (de != 0) begin failures++; $display("FAIL random_data got=%0d errs exp=0", de); end
    checks++; if (he != 0) begin failures++; $display("FAIL random_handshake got=%0d errs exp=0", he); end
    checks++; if (nd != 1) begin failures++; $display("FAIL random_done_pulses got=%0d exp=1", nd); end
  endtask

  task automatic test_reset_mid_stream();
    int sent, n_win, n_pix, first_wr, oe, de, he, se, sc, nd; bit to;
    sent = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000 && sent < 10*W + 3; c++) begin
      valid = 1'b1; data = 8'($urandom); win_ready = 1'b1;
      #1;
      if (we) sent++;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0 || we !== 1'b0) begin failures++; $display("FAIL midrst_ready_we got=%b%b exp=00", ready, we); end
    checks++; if (win_valid !== 1'b0 || win_row !== 5'd0 || win_col !== 5'd0) begin failures++; $display("FAIL midrst_window got=%b(%0d,%0d) exp=0(0,0)", win_valid, win_row, win_col); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_busy_done got=%b%b exp=00", busy, done); end
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0; win_ready = 1'b0;
    @(negedge clk);
    run_frame(70, 80, -1, 0, 1, n_win, n_pix, first_wr, oe, de, he, se, sc, nd, to);
    checks++; if (n_win != NWIN || oe != 0 || de != 0 || he != 0 || nd != 1 || to) begin
      failures++;
      $display("FAIL midrst_next_frame got=%0d wins o%0d d%0d h%0d done%0d exp=%0d wins 0 errs done1", n_win, oe, de, he, nd, NWIN);
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2, n_pix, first_wr, oe1, oe2, de, he, se, sc, nd1, nd2; bit to1, to2;
    run_frame(80, 80, -1, 1, 0, w1, n_pix, first_wr, oe1, de, he, se, sc, nd1, to1);
    run_frame(80, 80, -1, 0, 1, w2, n_pix, first_wr, oe2, de, he, se, sc, nd2, to2);
    checks++; if (w1 + w2 != 2*NWIN) begin failures++; $display("FAIL b2b_windows got=%0d exp=%0d", w1 + w2, 2*NWIN); end
    checks++; if (oe1 != 0 || oe2 != 0) begin failures++; $display("FAIL b2b_order got=%0d/%0d errs exp=0/0", oe1, oe2); end
    checks++; if (nd1 != 1 || nd2 != 1 || to1 || to2) begin failures++; $display("FAIL b2b_done got=%0d/%0d exp=1/1", nd1, nd2); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_small_frame();
    test_stall();
    test_random_gaps();
    test_reset_mid_stream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
